// File: rtl/booth_product_accumulator.sv
// Booth product accumulator: sums groups of up to N_TERMS signed products into a
// saturating AW-bit result, handed off over a valid/ready output port.
module booth_product_accumulator #(
  parameter int unsigned PW      = 8,
  parameter int unsigned AW      = 16,
  parameter int unsigned N_TERMS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PW-1:0]                 in_product,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [AW-1:0]                 out_sum,
  output logic [$clog2(N_TERMS+1)-1:0]  out_count,
  output logic                          out_ovf
);

  localparam int unsigned CW = $clog2(N_TERMS + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;

  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic                 accept;
  logic                 consume;
  logic                 close;
  logic signed [AW:0]   sum_wide;
  logic                 ovf_add;
  logic signed [AW-1:0] sat_sum;
  logic [CW-1:0]        cnt_inc;
  logic                 ovf_next;

  // Handshakes are qualified by state only, so nothing depends on the
  // upstream/downstream valid/ready combinationally beyond these gates.
  assign accept  = in_valid  && (state == ACCUM);
  assign consume = out_ready && (state == HOLD);

  // One guard bit is enough to detect overflow of acc + product since AW >= PW.
  assign sum_wide = (AW+1)'(acc) + (AW+1)'($signed(in_product));
  assign ovf_add  = sum_wide[AW] ^ sum_wide[AW-1];

  always_comb begin
    sat_sum = sum_wide[AW-1:0];
    if (ovf_add) begin
      if (sum_wide[AW]) begin
        sat_sum = {1'b1, {(AW-1){1'b0}}};
      end else begin
        sat_sum = {1'b0, {(AW-1){1'b1}}};
      end
    end
  end

  assign cnt_inc  = cnt + CW'(1);
  assign ovf_next = ovf | ovf_add;
  assign close    = accept && ((cnt_inc == CW'(N_TERMS)) || in_last);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (close)   state_next = HOLD;
      HOLD:  if (consume) state_next = ACCUM;
      default:            state_next = ACCUM;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Running group state and the captured result; the result registers are
  // only rewritten when a group closes, so they survive the consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc <= sat_sum;
      cnt <= cnt_inc;
      ovf <= ovf_next;
      if (close) begin
        out_sum   <= sat_sum;
        out_count <= cnt_inc;
        out_ovf   <= ovf_next;
      end
    end else if (consume) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

endmodule
